// File: rtl/hack_run_ctrl.sv
// Boot/run sequencer for the Hack CPU: streams a program into instruction ROM,
// releases CPU reset, and stops the run on halt address, cycle budget or request.
module hack_run_ctrl #(
  parameter int MAX_CYCLES = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [14:0]      load_len,
  input  logic [14:0]      halt_addr,
  input  logic             stop,
  input  logic             s_valid,
  input  logic [15:0]      s_data,
  output logic             s_ready,
  output logic             rom_we,
  output logic [14:0]      rom_addr,
  output logic [15:0]      rom_wdata,
  output logic             cpu_reset,
  input  logic [14:0]      cpu_pc,
  output logic             busy,
  output logic             done,
  output logic             hit,
  output logic             timeout,
  output logic [CNT_W-1:0] cycles
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, HALT} state_t;

  localparam logic [CNT_W-1:0] LAST_CYCLE = CNT_W'((MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0);

  state_t            state, state_n;
  logic [14:0]       remaining, remaining_n;
  logic [14:0]       addr, addr_n;
  logic [14:0]       halt_q, halt_n;
  logic [CNT_W-1:0]  cycles_n;
  logic              hit_n, timeout_n;
  logic              rom_we_n;
  logic [14:0]       rom_addr_n;
  logic [15:0]       rom_wdata_n;
  logic              accept;
  logic              budget_end;

  assign accept     = s_valid && s_ready;
  assign budget_end = (MAX_CYCLES != 0) && (cycles == LAST_CYCLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      addr      <= '0;
      halt_q    <= '0;
      cycles    <= '0;
      hit       <= 1'b0;
      timeout   <= 1'b0;
      rom_we    <= 1'b0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      s_ready   <= 1'b0;
      cpu_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      addr      <= addr_n;
      halt_q    <= halt_n;
      cycles    <= cycles_n;
      hit       <= hit_n;
      timeout   <= timeout_n;
      rom_we    <= rom_we_n;
      rom_addr  <= rom_addr_n;
      rom_wdata <= rom_wdata_n;
      // Status outputs are registered from the next state so they line up with it.
      s_ready   <= (state_n == LOAD);
      cpu_reset <= (state_n != RUN);
      busy      <= (state_n == LOAD) || (state_n == SETTLE) || (state_n == RUN);
      done      <= (state_n == HALT);
    end
  end

  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    addr_n      = addr;
    halt_n      = halt_q;
    cycles_n    = cycles;
    hit_n       = hit;
    timeout_n   = timeout;
    rom_we_n    = 1'b0;
    rom_addr_n  = rom_addr;
    rom_wdata_n = rom_wdata;
    case (state)
      IDLE, HALT: begin
        if (start) begin
          hit_n       = 1'b0;
          timeout_n   = 1'b0;
          cycles_n    = '0;
          halt_n      = halt_addr;
          addr_n      = '0;
          remaining_n = load_len;
          state_n     = (load_len != 15'd0) ? LOAD : SETTLE;
        end
      end
      LOAD: begin
        if (accept) begin
          rom_we_n    = 1'b1;
          rom_addr_n  = addr;
          rom_wdata_n = s_data;
          addr_n      = addr + 15'd1;
          remaining_n = remaining - 15'd1;
          if (remaining == 15'd1) state_n = SETTLE;
        end
      end
      SETTLE: state_n = RUN;
      RUN: begin
        // The exit cycle itself is counted; stop outranks halt match outranks budget.
        cycles_n = cycles + 1'b1;
        if (stop) begin
          state_n   = HALT;
          hit_n     = 1'b0;
          timeout_n = 1'b0;
        end else if (cpu_pc == halt_q) begin
          state_n = HALT;
          hit_n   = 1'b1;
        end else if (budget_end) begin
          state_n   = HALT;
          timeout_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_hack_run_ctrl.sv
// Directed bench for hack_run_ctrl; a toy PC model stands in for the CPU.
module tb_hack_run_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stop, s_valid;
  logic [14:0] load_len, halt_addr;
  logic [15:0] s_data;
  logic        s_ready, rom_we, cpu_reset, busy, done, hit, timeout;
  logic [14:0] rom_addr, cpu_pc;
  logic [15:0] rom_wdata;
  logic [31:0] cycles;

  int pass_cnt = 0;
  int total    = 0;

  // PC model: held at 0 in reset, then counts up (or loops 0..3 in loop_mode).
  logic        loop_mode = 1'b0;
  logic [14:0] pc = '0;
  assign cpu_pc = pc;

  // Write log of every ROM strobe seen.
  int          wn = 0;
  logic [14:0] log_addr [64];
  logic [15:0] log_data [64];

  hack_run_ctrl #(.MAX_CYCLES(10), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .load_len(load_len),
    .halt_addr(halt_addr), .stop(stop), .s_valid(s_valid), .s_data(s_data),
    .s_ready(s_ready), .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_reset(cpu_reset), .cpu_pc(cpu_pc), .busy(busy), .done(done),
    .hit(hit), .timeout(timeout), .cycles(cycles)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cpu_reset) pc <= '0;
    else if (loop_mode) pc <= (pc + 15'd1) & 15'd3;
    else pc <= pc + 15'd1;
  end

  always @(posedge clk) begin
    if (rom_we) begin
      if (wn < 64) begin
        log_addr[wn] = rom_addr;
        log_data[wn] = rom_wdata;
      end
      wn = wn + 1;
    end
  end

  task automatic pulse_start(input logic [14:0] len, input logic [14:0] ha);
    load_len  = len;
    halt_addr = ha;
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (done !== 1'b1) $display("FAIL %s_done_wait: done=%b after %0d cycles, required 1", tag, done, n);
    else pass_cnt++;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; stop = 1'b0; s_valid = 1'b0; s_data = '0;
    load_len = '0; halt_addr = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({cpu_reset, s_ready, rom_we, busy, done, hit, timeout} !== 7'b1000000)
      $display("FAIL reset_flags: got %b required 1000000",
               {cpu_reset, s_ready, rom_we, busy, done, hit, timeout});
    else pass_cnt++;
    total++;
    if (rom_addr !== 15'd0 || rom_wdata !== 16'd0 || cycles !== 32'd0)
      $display("FAIL reset_values: addr=%0d wdata=%h cycles=%0d required 0/0000/0", rom_addr, rom_wdata, cycles);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load_stream;
    logic [15:0] w [3];
    w[0] = 16'h0002; w[1] = 16'hEC10; w[2] = 16'h0002;
    s_valid = 1'b1; s_data = w[0];
    pulse_start(15'd3, 15'h7FFF);
    total++;
    if (s_ready !== 1'b1 || busy !== 1'b1 || cpu_reset !== 1'b1 || rom_we !== 1'b0)
      $display("FAIL load_entry: s_ready=%b busy=%b cpu_reset=%b rom_we=%b required 1 1 1 0", s_ready, busy, cpu_reset, rom_we);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      s_data = w[i];
      @(negedge clk);
      total++;
      if (rom_we !== 1'b1 || rom_addr !== 15'(i) || rom_wdata !== w[i])
        $display("FAIL load_write%0d: we=%b addr=%0d data=%h required 1 %0d %h", i, rom_we, rom_addr, rom_wdata, i, w[i]);
      else pass_cnt++;
    end
    s_valid = 1'b0;
    total++;
    if (s_ready !== 1'b0 || cpu_reset !== 1'b1 || busy !== 1'b1)
      $display("FAIL settle_state: s_ready=%b cpu_reset=%b busy=%b required 0 1 1", s_ready, cpu_reset, busy);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (cpu_reset !== 1'b0 || rom_we !== 1'b0)
      $display("FAIL run_entry: cpu_reset=%b rom_we=%b required 0 0", cpu_reset, rom_we);
    else pass_cnt++;
    wait_done("load_stream");
    total++;
    if (timeout !== 1'b1 || hit !== 1'b0 || cycles !== 32'd10)
      $display("FAIL linear_timeout: timeout=%b hit=%b cycles=%0d required 1 0 10", timeout, hit, cycles);
    else pass_cnt++;
  endtask

  task automatic test_gappy_load;
    logic [15:0] w [4];
    int k = 0;
    int n = 0;
    int base;
    w[0] = 16'h1111; w[1] = 16'h2222; w[2] = 16'h3333; w[3] = 16'h4444;
    base = wn;
    s_valid = 1'b0;
    pulse_start(15'd4, 15'd2);
    while (k < 4 && n < 40) begin
      s_valid = ~s_valid;
      s_data  = s_valid ? w[k] : 16'hDEAD;
      if (s_valid && s_ready) k++;
      @(negedge clk);
      n++;
    end
    s_valid = 1'b0;
    total++;
    if (s_ready !== 1'b0) $display("FAIL gappy_ready_drop: s_ready=%b required 0", s_ready);
    else pass_cnt++;
    wait_done("gappy");
    total++;
    if (wn - base !== 4) $display("FAIL gappy_write_count: got %0d required 4", wn - base);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (log_addr[base+i] !== 15'(i) || log_data[base+i] !== w[i])
        $display("FAIL gappy_write%0d: addr=%0d data=%h required %0d %h", i, log_addr[base+i], log_data[base+i], i, w[i]);
      else pass_cnt++;
    end
    total++;
    if (hit !== 1'b1 || cycles !== 32'd3)
      $display("FAIL gappy_hit: hit=%b cycles=%0d required 1 3", hit, cycles);
    else pass_cnt++;
  endtask

  task automatic test_zero_len;
    pulse_start(15'd0, 15'd0);
    total++;
    if (busy !== 1'b1 || cpu_reset !== 1'b1 || s_ready !== 1'b0 || done !== 1'b0)
      $display("FAIL zero_settle: busy=%b cpu_reset=%b s_ready=%b done=%b required 1 1 0 0", busy, cpu_reset, s_ready, done);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (cpu_reset !== 1'b0) $display("FAIL zero_run: cpu_reset=%b required 0", cpu_reset);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (done !== 1'b1 || hit !== 1'b1 || timeout !== 1'b0 || cycles !== 32'd1 || cpu_reset !== 1'b1 || busy !== 1'b0)
      $display("FAIL zero_halt: done=%b hit=%b timeout=%b cycles=%0d cpu_reset=%b busy=%b required 1 1 0 1 1 0",
               done, hit, timeout, cycles, cpu_reset, busy);
    else pass_cnt++;
  endtask

  task automatic test_halt_and_timeout;
    s_valid = 1'b1; s_data = 16'h0005;
    pulse_start(15'd2, 15'd5);
    @(negedge clk);
    s_data = 16'hEA87;
    @(negedge clk);
    s_valid = 1'b0;
    wait_done("halt5");
    // pc trace 0,1,2,3,4,5 -> six RUN cycles
    total++;
    if (hit !== 1'b1 || timeout !== 1'b0 || cycles !== 32'd6)
      $display("FAIL halt5: hit=%b timeout=%b cycles=%0d required 1 0 6", hit, timeout, cycles);
    else pass_cnt++;
    loop_mode = 1'b1;
    pulse_start(15'd0, 15'd5);
    wait_done("loop_timeout");
    total++;
    if (timeout !== 1'b1 || hit !== 1'b0 || cycles !== 32'd10)
      $display("FAIL loop_timeout: timeout=%b hit=%b cycles=%0d required 1 0 10", timeout, hit, cycles);
    else pass_cnt++;
    loop_mode = 1'b0;
  endtask

  task automatic test_stop_priority;
    pulse_start(15'd0, 15'd3);
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if (done !== 1'b1 || hit !== 1'b0 || timeout !== 1'b0 || cycles !== 32'd4)
      $display("FAIL stop_priority: done=%b hit=%b timeout=%b cycles=%0d required 1 0 0 4", done, hit, timeout, cycles);
    else pass_cnt++;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    total++;
    if (done !== 1'b1 || cycles !== 32'd4 || busy !== 1'b0)
      $display("FAIL stop_in_halt: done=%b cycles=%0d busy=%b required 1 4 0", done, cycles, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_load;
    s_valid = 1'b1; s_data = 16'hAAAA;
    pulse_start(15'd5, 15'd0);
    @(negedge clk);
    s_data = 16'hBBBB;
    @(negedge clk);
    total++;
    if (rom_we !== 1'b1 || rom_addr !== 15'd1)
      $display("FAIL midload_second: we=%b addr=%0d required 1 1", rom_we, rom_addr);
    else pass_cnt++;
    s_data = 16'hCCCC;
    reset  = 1'b1;
    @(negedge clk);
    reset   = 1'b0;
    s_valid = 1'b0;
    total++;
    if ({cpu_reset, s_ready, rom_we, busy, done, hit, timeout} !== 7'b1000000 ||
        rom_addr !== 15'd0 || rom_wdata !== 16'd0 || cycles !== 32'd0)
      $display("FAIL midload_reset: flags=%b addr=%0d wdata=%h cycles=%0d required 1000000 0 0000 0",
               {cpu_reset, s_ready, rom_we, busy, done, hit, timeout}, rom_addr, rom_wdata, cycles);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (rom_we !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL midload_idle: rom_we=%b s_ready=%b required 0 0", rom_we, s_ready);
    else pass_cnt++;
  endtask

  task automatic test_start_ignored_and_restart;
    pulse_start(15'd0, 15'h7FFF);
    repeat (2) @(negedge clk);
    pulse_start(15'd3, 15'd0);
    total++;
    if (s_ready !== 1'b0 || cpu_reset !== 1'b0)
      $display("FAIL start_in_run: s_ready=%b cpu_reset=%b required 0 0", s_ready, cpu_reset);
    else pass_cnt++;
    wait_done("ignored_start");
    total++;
    if (timeout !== 1'b1 || cycles !== 32'd10)
      $display("FAIL ignored_start_run: timeout=%b cycles=%0d required 1 10", timeout, cycles);
    else pass_cnt++;
    pulse_start(15'd0, 15'd0);
    total++;
    if (done !== 1'b0 || timeout !== 1'b0 || hit !== 1'b0 || cycles !== 32'd0 || busy !== 1'b1)
      $display("FAIL restart_clear: done=%b timeout=%b hit=%b cycles=%0d busy=%b required 0 0 0 0 1",
               done, timeout, hit, cycles, busy);
    else pass_cnt++;
    wait_done("restart");
    total++;
    if (hit !== 1'b1 || timeout !== 1'b0 || cycles !== 32'd1)
      $display("FAIL restart_hit: hit=%b timeout=%b cycles=%0d required 1 0 1", hit, timeout, cycles);
    else pass_cnt++;
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_load_stream;
    test_gappy_load;
    test_zero_len;
    test_halt_and_timeout;
    test_stop_priority;
    test_reset_mid_load;
    test_start_ignored_and_restart;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
